// File: rtl/light_share_ctrl.sv
// light_share_ctrl: round-robin sharing of one light among push buttons; define LIGHT_SHARE_DEBOUNCE_EN to debounce inputs
module light_share_ctrl #(
  parameter int N_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int OW = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] button_in,
  output logic             light,
  output logic [OW-1:0]    owner,
  output logic [N_BTN-1:0] pending,
  output logic             grant_pulse
);
  localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0, LIT = 1'b1;
  logic [N_BTN-1:0] s1_q, s_q, c, cd_q, mask_q, mask_d, press, upd, pend_q, pend_d;
  logic [1:0] warm_q;
  logic [0:0] st_q, st_d;
  logic [OW-1:0] own_q, own_d, rr_q, rr_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic gp_q, gp_d, rel;

  function automatic logic [OW-1:0] pick(input logic [N_BTN-1:0] v, input logic [OW-1:0] st);
    int k;
    pick = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      k = (int'(st) + i) % N_BTN;
      if (v[k[OW-1:0]]) pick = k[OW-1:0];
    end
  endfunction

  // two-flop synchronizer per button
  always_ff @(posedge clk)
    if (!reset_n) begin
      s1_q <= '0;
      s_q  <= '0;
    end else begin
      s1_q <= button_in;
      s_q  <= s1_q;
    end

`ifdef LIGHT_SHARE_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [N_BTN-1:0][DW-1:0] cnt_q;
  logic [N_BTN-1:0] c_q;
  // clean level follows the synchronized level only after it has differed for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt_q <= '0;
      c_q   <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++)
        if (s_q[i] == c_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          c_q[i]   <= s_q[i];
        end else cnt_q[i] <= cnt_q[i] + DW'(1);
    end
  assign c = c_q;
`else
  assign c = s_q;
`endif

  // a button held through reset stays masked until it has been seen released
  assign mask_d = warm_q[1] ? (mask_q & (s_q | c)) : mask_q;
  assign press  = c & ~cd_q & ~mask_q;

  // edge-detect history and post-reset mask
  always_ff @(posedge clk)
    if (!reset_n) begin
      cd_q   <= '0;
      warm_q <= '0;
      mask_q <= '1;
    end else begin
      cd_q   <= c;
      warm_q <= {warm_q[0], 1'b1};
      mask_q <= mask_d;
    end

  // arbitration: grant, queue/cancel, release and handover
  always_comb begin
    st_d   = st_q;
    own_d  = own_q;
    rr_d   = rr_q;
    pend_d = pend_q;
    tmr_d  = tmr_q;
    gp_d   = 1'b0;
    upd    = pend_q ^ (press & ~(N_BTN'(1) << own_q));
    rel    = press[own_q] | (HOLD_CYCLES != 0 && tmr_q == '0);
    if (st_q == IDLE) begin
      if (|press) begin
        own_d  = pick(press, rr_q);
        pend_d = press & ~(N_BTN'(1) << own_d);
        st_d   = LIT;
        tmr_d  = TW'(HOLD_CYCLES - 1);
        gp_d   = 1'b1;
      end
    end else begin
      pend_d = upd;
      tmr_d  = tmr_q - TW'(1);
      if (rel) begin
        rr_d = (int'(own_q) == N_BTN - 1) ? '0 : own_q + OW'(1);
        if (|upd) begin
          own_d  = pick(upd, rr_d);
          pend_d = upd & ~(N_BTN'(1) << own_d);
          tmr_d  = TW'(HOLD_CYCLES - 1);
          gp_d   = 1'b1;
        end else st_d = IDLE;
      end
    end
  end

  // arbiter state registers
  always_ff @(posedge clk)
    if (!reset_n) begin
      st_q   <= IDLE;
      own_q  <= '0;
      rr_q   <= '0;
      pend_q <= '0;
      tmr_q  <= '0;
      gp_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      own_q  <= own_d;
      rr_q   <= rr_d;
      pend_q <= pend_d;
      tmr_q  <= tmr_d;
      gp_q   <= gp_d;
    end

  assign light       = st_q;
  assign owner       = own_q;
  assign pending     = pend_q;
  assign grant_pulse = gp_q;
endmodule

// File: tb/tb_light_share_ctrl.sv
// tb_light_share_ctrl: directed vector bench for light_share_ctrl
module tb_light_share_ctrl;
  localparam int DEB = 4;
`ifdef LIGHT_SHARE_DEBOUNCE_EN
  localparam int L = 3 + DEB, BG = 1, BF = 0;
`else
  localparam int L = 3, BG = 2, BF = 1;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    int         cyc;
    logic       light;
    logic [1:0] own;
    logic [3:0] pend;
    logic       gp;
  } vec_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] button_in = 4'b0100;
  logic light, grant_pulse;
  logic [1:0] owner;
  logic [3:0] pending;
  int n_chk = 0, n_fail = 0;
  vec_t tv [25];

  light_share_ctrl #(.N_BTN(4), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(20)) dut (
    .clk(clk), .reset_n(reset_n), .button_in(button_in),
    .light(light), .owner(owner), .pending(pending), .grant_pulse(grant_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    button_in = '0;
    @(negedge clk);
    chk("rst_light", 32'(light), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_gp", 32'(grant_pulse), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int lit, gps, falls;
    logic prev;
    // single press and timeout
    tv[0]  = '{1'b1, 4'b0010, L - 1,  1'b0, 2'd0, 4'b0000, 1'b0};
    tv[1]  = '{1'b0, 4'b0010, 1,      1'b1, 2'd1, 4'b0000, 1'b1};
    tv[2]  = '{1'b0, 4'b0010, 1,      1'b1, 2'd1, 4'b0000, 1'b0};
    tv[3]  = '{1'b0, 4'b0000, 18,     1'b1, 2'd1, 4'b0000, 1'b0};
    tv[4]  = '{1'b0, 4'b0000, 1,      1'b0, 2'd0, 4'b0000, 1'b0};
    // queue and handover
    tv[5]  = '{1'b1, 4'b0101, L,      1'b1, 2'd0, 4'b0100, 1'b1};
    tv[6]  = '{1'b0, 4'b0000, 5,      1'b1, 2'd0, 4'b0100, 1'b0};
    tv[7]  = '{1'b0, 4'b0001, L - 1,  1'b1, 2'd0, 4'b0100, 1'b0};
    tv[8]  = '{1'b0, 4'b0001, 1,      1'b1, 2'd2, 4'b0000, 1'b1};
    tv[9]  = '{1'b0, 4'b0000, 1,      1'b1, 2'd2, 4'b0000, 1'b0};
    // cancel, then timeout with an empty queue
    tv[10] = '{1'b1, 4'b1000, L,      1'b1, 2'd3, 4'b0000, 1'b1};
    tv[11] = '{1'b0, 4'b0010, L,      1'b1, 2'd3, 4'b0010, 1'b0};
    tv[12] = '{1'b0, 4'b0000, 5,      1'b1, 2'd3, 4'b0010, 1'b0};
    tv[13] = '{1'b0, 4'b0010, L,      1'b1, 2'd3, 4'b0000, 1'b0};
    tv[14] = '{1'b0, 4'b0000, 15 - 2 * L, 1'b0, 2'd0, 4'b0000, 1'b0};
    // presses coinciding with owner 3 timeout: round robin wraps to 0
    tv[15] = '{1'b1, 4'b1000, L,      1'b1, 2'd3, 4'b0000, 1'b1};
    tv[16] = '{1'b0, 4'b0000, 20 - L, 1'b1, 2'd3, 4'b0000, 1'b0};
    tv[17] = '{1'b0, 4'b0011, L - 1,  1'b1, 2'd3, 4'b0000, 1'b0};
    tv[18] = '{1'b0, 4'b0011, 1,      1'b1, 2'd0, 4'b0010, 1'b1};
    tv[19] = '{1'b0, 4'b0000, 1,      1'b1, 2'd0, 4'b0010, 1'b0};
    // owner press coinciding with timeout: single release
    tv[20] = '{1'b1, 4'b0100, L,      1'b1, 2'd2, 4'b0000, 1'b1};
    tv[21] = '{1'b0, 4'b0000, 20 - L, 1'b1, 2'd2, 4'b0000, 1'b0};
    tv[22] = '{1'b0, 4'b0100, L - 1,  1'b1, 2'd2, 4'b0000, 1'b0};
    tv[23] = '{1'b0, 4'b0100, 1,      1'b0, 2'd0, 4'b0000, 1'b0};
    tv[24] = '{1'b0, 4'b0100, 4,      1'b0, 2'd0, 4'b0000, 1'b0};

    // reset with button 2 held throughout
    repeat (5) @(negedge clk);
    chk("hold_rst_light", 32'(light), 0);
    chk("hold_rst_pend", 32'(pending), 0);
    chk("hold_rst_gp", 32'(grant_pulse), 0);
    reset_n = 1'b1;
    lit = 0;
    repeat (20) begin
      @(negedge clk);
      if (light) lit++;
    end
    chk("held_no_grant", 32'(lit), 0);
    button_in = '0;
    repeat (8) @(negedge clk);
    button_in = 4'b0100;
    repeat (L) @(negedge clk);
    chk("repress_light", 32'(light), 1);
    chk("repress_owner", 32'(owner), 2);
    chk("repress_gp", 32'(grant_pulse), 1);

    // bouncing button 0
    do_reset();
    gps = 0;
    falls = 0;
    prev = 1'b0;
    for (int k = 0; k < 24; k++) begin
      button_in = {3'b000, (k == 0 || k == 2 || k >= 4)};
      @(negedge clk);
      gps += int'(grant_pulse);
      if (prev && !light) falls++;
      prev = light;
    end
    chk("bounce_grants", 32'(gps), 32'(BG));
    chk("bounce_releases", 32'(falls), 32'(BF));
    chk("bounce_light", 32'(light), 1);
    chk("bounce_owner", 32'(owner), 0);

    for (int i = 0; i < 25; i++) begin
      if (tv[i].rst) do_reset();
      button_in = tv[i].btn;
      repeat (tv[i].cyc) @(negedge clk);
      chk($sformatf("v%0d_light", i), 32'(light), 32'(tv[i].light));
      chk($sformatf("v%0d_pend", i), 32'(pending), 32'(tv[i].pend));
      chk($sformatf("v%0d_gp", i), 32'(grant_pulse), 32'(tv[i].gp));
      if (tv[i].light) chk($sformatf("v%0d_owner", i), 32'(owner), 32'(tv[i].own));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/light_share_ctrl.md
# light_share_ctrl

Shares one indicator light between several push-button requesters. Each button is synchronized, optionally debounced, and edge-detected. A round-robin scheduler grants ownership of the light, queues competing requests, and releases the light either on an owner press or after a hold timeout. It sits between the raw board buttons and the single LED output, replacing the per-button on/off toggle with a shared, arbitrated light.

## Interface
- `N_BTN`, 4: number of requesters, range 2..8.
- `DEBOUNCE_CYCLES`, 16: required stable-input length in clocks, ≥1; used only when debouncing is compiled in.
- `HOLD_CYCLES`, 1000: auto-release timeout in clocks; 0 disables the timeout.
- `OW`, $clog2(N_BTN): owner index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `button_in` in N_BTN: raw asynchronous buttons, active-high.
- `light` out 1: shared light, 1 = on.
- `owner` out OW: index of the current owner; valid only when `light`=1.
- `pending` out N_BTN: queued requests, one bit per button.
- `grant_pulse` out 1: one-cycle pulse on every new grant, including handovers.

## Operation
- Per-channel front end:
  - 2-flop synchronizer produces `s`.
  - With debounce, clean level `c` tracks `s` as described under Configuration.
  - A press is `c` & ~`c_d` (one cycle). Releases are ignored.
- Two-state FSM: IDLE and LIT. Round-robin pointer `rr` holds the highest-priority index.
- IDLE:
  - Any press: grant the first pressed index searching upward from `rr` (wrapping).
  - Other simultaneous presses set their `pending` bits.
  - Go to LIT and load the timer.
- LIT, press by owner: release event.
- LIT, press by non-owner:
  - If its `pending` bit is 0, set it.
  - If its `pending` bit is 1, clear it (cancel).
- LIT, timer reaches 0 with `HOLD_CYCLES`≠0: release event.
- Release event:
  - `rr` ← owner+1 (mod N_BTN).
  - If `pending`≠0: hand over to the first pending index from the new `rr`, clear that bit, reload the timer, pulse `grant_pulse`, stay LIT with `light` held at 1.
  - Otherwise go to IDLE, `light`=0.
- Simultaneous events in the same cycle:
  - Owner press and timeout together = one release.
  - Non-owner presses in a release cycle update `pending` first. The handover search uses the updated `pending`.
- Timer:
  - Width $clog2(HOLD_CYCLES+1).
  - Loaded with HOLD_CYCLES-1 on grant; decrements each LIT cycle.
  - Expiry happens HOLD_CYCLES cycles after the grant edge.

## Timing
- Reset (reset_n=0 at an edge) clears:
  - `light`=0, `owner`=0, `pending`=0, `grant_pulse`=0
  - `rr`=0, timer=0, FSM=IDLE
  - synchronizers, clean levels and debounce counters = 0
- Reset mid-operation drops the owner and all pending requests immediately. No press is generated while a button is still held after reset until it is released and pressed again. This holds because `c` must first return to 0.
- Latency from `button_in` rising (setup met before edge 1) to `light`/`grant_pulse` update:
  - Without debounce: edge 3.
  - With debounce: edge 3+DEBOUNCE_CYCLES.
- All outputs are registered. `grant_pulse` is high exactly one cycle and coincides with the first cycle of the new `owner`.

## Configuration
- `LIGHT_SHARE_DEBOUNCE_EN` defined:
  - Each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - It counts consecutive cycles with `s`≠`c`. Any cycle with `s`=`c` resets it to 0.
  - `c` ← `s` at the edge where the count would reach DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press.
- Undefined: `c`=`s`, no counters; every synchronized rising edge is a press.

## Test plan
Parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, N_BTN=4, 10 ns clock.
- **Reset:** hold reset_n=0 for 5 cycles with button 2 held high -> `light`=0, `pending`=0. After reset_n=1, no grant until button 2 is released and re-pressed.
- **Single press and timeout:** press button 1 for 10 cycles -> `light`=1, `owner`=1, `grant_pulse` at edge 7; `light`=0 exactly 20 cycles later.
- **Bounce filtering (debounce compiled in):** pulses of 10/10/10 ns, then steady 200 ns -> exactly one grant. Without the macro -> three presses, so button 0 grants, then releases, then grants again.
- **Queue and handover:** buttons 0 and 2 pressed in the same cycle -> `owner`=0, `pending`=4'b0100. Owner 0 presses -> same-edge handover to `owner`=2 with `light` kept at 1 and `grant_pulse` high.
- **Cancel and round-robin:**
  - Owner 3: press 1, press 1 again -> `pending`=0.
  - Then press 0 and 1 together while owner 3 times out -> grant goes to 0 (rr=0), and `pending`=4'b0010.
- **Coincident owner press and timeout** -> single release, `light` goes 0 once, no re-grant to the same owner.
